lsu_issue_queue: RTL and testbench



---
 rtl/rv32i_types_pkg.sv | 33 +++
 rtl/lsu_issue_queue_if.sv | 59 +++++
 rtl/lsu_iq_operand.sv | 71 +++++++
 rtl/lsu_issue_queue.sv | 129 ++++++++++++
 tb/tb_lsu_issue_queue.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types_pkg.sv
// Shared RV32I core types used by the load-store issue path.
//   NUM_CB_ENTRY          : completion-buffer depth (sets the tag width)
//   lsu_control_signals_t : control bundle travelling with a memory op
//   lsu_iq_src_t          : one source operand slot {rdy, tag, data}
//   lsu_iq_entry_t        : full issue-queue entry layout
package rv32i_types_pkg;

  localparam int NUM_CB_ENTRY = 16;
  localparam int CB_IDX_W     = $clog2(NUM_CB_ENTRY);

  typedef struct packed {
    logic                is_load;
    logic                is_store;
    logic [2:0]          size;
    logic                sign_ext;
    logic [CB_IDX_W-1:0] cb_index;
  } lsu_control_signals_t;

  typedef struct packed {
    logic                rdy;
    logic [CB_IDX_W-1:0] tag;
    logic [31:0]         data;
  } lsu_iq_src_t;

  typedef struct packed {
    lsu_control_signals_t ctrl;
    logic [31:0]          pc;
    logic [31:0]          imm;
    lsu_iq_src_t          rs1;
    lsu_iq_src_t          rs2;
  } lsu_iq_entry_t;

endpackage

// File: rtl/lsu_issue_queue_if.sv
// Handshake bundle around the load-store issue queue.
//   dispatch side : disp_* in, disp_ready out
//   writeback     : wb_valid / wb_index / wb_data in
//   issue side    : busy_ls in, iss_* out
//   misc          : flush in, count out
// slave = the queue, master = its environment.
interface lsu_issue_queue_if #(
  parameter int DEPTH = 4,
  parameter int CB_W  = $clog2(rv32i_types_pkg::NUM_CB_ENTRY)
);
  import rv32i_types_pkg::*;

  logic                 flush;

  logic                 disp_valid;
  logic                 disp_ready;
  lsu_control_signals_t disp_ctrl;
  logic [31:0]          disp_pc;
  logic [31:0]          disp_imm;
  logic                 disp_rs1_rdy;
  logic [CB_W-1:0]      disp_rs1_tag;
  logic [31:0]          disp_rs1_data;
  logic                 disp_rs2_rdy;
  logic [CB_W-1:0]      disp_rs2_tag;
  logic [31:0]          disp_rs2_data;

  logic                 wb_valid;
  logic [CB_W-1:0]      wb_index;
  logic [31:0]          wb_data;

  logic                 busy_ls;
  logic                 iss_valid;
  lsu_control_signals_t iss_ctrl;
  logic [31:0]          iss_port_a;
  logic [31:0]          iss_port_b;
  logic [31:0]          iss_store_data;
  logic [31:0]          iss_pc;

  logic [$clog2(DEPTH):0] count;

  modport slave (
    input  flush, disp_valid, disp_ctrl, disp_pc, disp_imm,
           disp_rs1_rdy, disp_rs1_tag, disp_rs1_data,
           disp_rs2_rdy, disp_rs2_tag, disp_rs2_data,
           wb_valid, wb_index, wb_data, busy_ls,
    output disp_ready, iss_valid, iss_ctrl, iss_port_a, iss_port_b,
           iss_store_data, iss_pc, count
  );

  modport master (
    output flush, disp_valid, disp_ctrl, disp_pc, disp_imm,
           disp_rs1_rdy, disp_rs1_tag, disp_rs1_data,
           disp_rs2_rdy, disp_rs2_tag, disp_rs2_data,
           wb_valid, wb_index, wb_data, busy_ls,
    input  disp_ready, iss_valid, iss_ctrl, iss_port_a, iss_port_b,
           iss_store_data, iss_pc, count
  );

endinterface

// File: rtl/lsu_iq_operand.sv
// One source-operand slot of an issue-queue entry: holds rdy/tag/data and
// captures the writeback broadcast whose index matches its tag.
//   CLK, nRST            : clock, async active-low reset
//   clr_i                : flush, drops the ready bit
//   wr_i, wr_*_i         : dispatch write of this slot
//   wb_valid_i/index/data: writeback broadcast
//   rdy_o, data_o        : registered operand state
module lsu_iq_operand
  import rv32i_types_pkg::*;
#(
  parameter int CB_W = CB_IDX_W
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            clr_i,
  input  logic            wr_i,
  input  logic            wr_rdy_i,
  input  logic [CB_W-1:0] wr_tag_i,
  input  logic [31:0]     wr_data_i,
  input  logic            wb_valid_i,
  input  logic [CB_W-1:0] wb_index_i,
  input  logic [31:0]     wb_data_i,
  output logic            rdy_o,
  output logic [31:0]     data_o
);

  logic            rdy_q, rdy_d;
  logic [CB_W-1:0] tag_q, tag_d;
  logic [31:0]     data_q, data_d;

  always_comb begin
    rdy_d  = rdy_q;
    tag_d  = tag_q;
    data_d = data_q;
    if (clr_i) begin
      rdy_d = 1'b0;
    end else if (wr_i) begin
      tag_d = wr_tag_i;
      if (wr_rdy_i) begin
        rdy_d  = 1'b1;
        data_d = wr_data_i;
      end else if (wb_valid_i && (wb_index_i == wr_tag_i)) begin
        // producer broadcasts in the same cycle the consumer is dispatched
        rdy_d  = 1'b1;
        data_d = wb_data_i;
      end else begin
        rdy_d  = 1'b0;
        data_d = wr_data_i;
      end
    end else if (!rdy_q && wb_valid_i && (wb_index_i == tag_q)) begin
      rdy_d  = 1'b1;
      data_d = wb_data_i;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rdy_q  <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
    end else begin
      rdy_q  <= rdy_d;
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

  assign rdy_o  = rdy_q;
  assign data_o = data_q;

endmodule

// File: rtl/lsu_issue_queue.sv
// In-order issue queue in front of the load-store unit execute port.
// Buffers dispatched memory ops, wakes their sources from the writeback
// broadcast, and issues the head when both sources are ready and the LSU
// is free. Ops leave strictly in program order.
//   CLK  : clock
//   nRST : async active-low reset
//   bus  : lsu_issue_queue_if.slave (dispatch, writeback, issue, flush, count)
module lsu_issue_queue
  import rv32i_types_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CB_W  = $clog2(NUM_CB_ENTRY)
) (
  input logic              CLK,
  input logic              nRST,
  lsu_issue_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  lsu_control_signals_t ctrl_q [DEPTH];
  logic [31:0]          pc_q   [DEPTH];
  logic [31:0]          imm_q  [DEPTH];

  logic        rs1_rdy  [DEPTH];
  logic [31:0] rs1_data [DEPTH];
  logic        rs2_rdy  [DEPTH];
  logic [31:0] rs2_data [DEPTH];

  logic disp_fire;
  logic iss_fire;

  // No pass-through when full: a same-cycle pop does not free a slot early.
  assign bus.disp_ready = (count_q != CNT_W'(DEPTH));
  assign disp_fire      = bus.disp_valid && bus.disp_ready && !bus.flush;
  assign iss_fire       = (count_q != '0) && rs1_rdy[head_q] && rs2_rdy[head_q]
                          && !bus.busy_ls && !bus.flush;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic wr_en;
    assign wr_en = disp_fire && (tail_q == PTR_W'(i));

    lsu_iq_operand #(.CB_W(CB_W)) u_rs1 (
      .CLK        (CLK),
      .nRST       (nRST),
      .clr_i      (bus.flush),
      .wr_i       (wr_en),
      .wr_rdy_i   (bus.disp_rs1_rdy),
      .wr_tag_i   (bus.disp_rs1_tag),
      .wr_data_i  (bus.disp_rs1_data),
      .wb_valid_i (bus.wb_valid),
      .wb_index_i (bus.wb_index),
      .wb_data_i  (bus.wb_data),
      .rdy_o      (rs1_rdy[i]),
      .data_o     (rs1_data[i])
    );

    lsu_iq_operand #(.CB_W(CB_W)) u_rs2 (
      .CLK        (CLK),
      .nRST       (nRST),
      .clr_i      (bus.flush),
      .wr_i       (wr_en),
      .wr_rdy_i   (bus.disp_rs2_rdy),
      .wr_tag_i   (bus.disp_rs2_tag),
      .wr_data_i  (bus.disp_rs2_data),
      .wb_valid_i (bus.wb_valid),
      .wb_index_i (bus.wb_index),
      .wb_data_i  (bus.wb_data),
      .rdy_o      (rs2_rdy[i]),
      .data_o     (rs2_data[i])
    );
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (disp_fire) tail_d = tail_q + PTR_W'(1);
      if (iss_fire)  head_d = head_q + PTR_W'(1);
      case ({disp_fire, iss_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_q[i] <= '0;
        pc_q[i]   <= '0;
        imm_q[i]  <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (disp_fire) begin
        ctrl_q[tail_q] <= bus.disp_ctrl;
        pc_q[tail_q]   <= bus.disp_pc;
        imm_q[tail_q]  <= bus.disp_imm;
      end
    end
  end

  // Issue outputs come straight from the head entry registers.
  assign bus.iss_valid      = iss_fire;
  assign bus.iss_ctrl       = ctrl_q[head_q];
  assign bus.iss_pc         = pc_q[head_q];
  assign bus.iss_port_a     = rs1_data[head_q];
  assign bus.iss_port_b     = imm_q[head_q];
  assign bus.iss_store_data = rs2_data[head_q];
  assign bus.count          = count_q;

endmodule

// File: tb/tb_lsu_issue_queue.sv
module tb_lsu_issue_queue;
  import rv32i_types_pkg::*;

  localparam int DEPTH = 4;
  localparam int CB_W  = $clog2(NUM_CB_ENTRY);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct {
    lsu_control_signals_t ctrl;
    logic [31:0]          a;
    logic [31:0]          b;
    logic [31:0]          sd;
    logic [31:0]          pc;
  } exp_t;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  int   tests_run = 0;
  int   failures  = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  lsu_issue_queue_if #(.DEPTH(DEPTH), .CB_W(CB_W)) bus ();

  lsu_issue_queue #(.DEPTH(DEPTH), .CB_W(CB_W)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  // scoreboard: every issue the DUT announces must match the oldest expectation
  always @(negedge CLK) begin
    if (nRST && bus.iss_valid) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_issue: got pc=%h with no op expected", bus.iss_pc);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.iss_ctrl !== mon_e.ctrl || bus.iss_port_a !== mon_e.a ||
            bus.iss_port_b !== mon_e.b || bus.iss_store_data !== mon_e.sd ||
            bus.iss_pc !== mon_e.pc) begin
          failures++;
          $display("FAIL issue_data: got ctrl=%h a=%h b=%h sd=%h pc=%h, want ctrl=%h a=%h b=%h sd=%h pc=%h",
                   bus.iss_ctrl, bus.iss_port_a, bus.iss_port_b, bus.iss_store_data, bus.iss_pc,
                   mon_e.ctrl, mon_e.a, mon_e.b, mon_e.sd, mon_e.pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic lsu_control_signals_t mk_ctrl(input logic st, input logic [CB_W-1:0] cb);
    lsu_control_signals_t c;
    c.is_load  = !st;
    c.is_store = st;
    c.size     = 3'b010;
    c.sign_ext = 1'b0;
    c.cb_index = cb;
    return c;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush = 1'b0; bus.disp_valid = 1'b0; bus.disp_ctrl = '0;
    bus.disp_pc = '0; bus.disp_imm = '0;
    bus.disp_rs1_rdy = 1'b0; bus.disp_rs1_tag = '0; bus.disp_rs1_data = '0;
    bus.disp_rs2_rdy = 1'b0; bus.disp_rs2_tag = '0; bus.disp_rs2_data = '0;
    bus.wb_valid = 1'b0; bus.wb_index = '0; bus.wb_data = '0;
    bus.busy_ls = 1'b0;
  endtask

  task automatic drive_disp(input lsu_control_signals_t c, input logic [31:0] pc, input logic [31:0] imm,
                            input logic r1rdy, input logic [CB_W-1:0] r1tag, input logic [31:0] r1data,
                            input logic r2rdy, input logic [CB_W-1:0] r2tag, input logic [31:0] r2data);
    bus.disp_valid = 1'b1; bus.disp_ctrl = c; bus.disp_pc = pc; bus.disp_imm = imm;
    bus.disp_rs1_rdy = r1rdy; bus.disp_rs1_tag = r1tag; bus.disp_rs1_data = r1data;
    bus.disp_rs2_rdy = r2rdy; bus.disp_rs2_tag = r2tag; bus.disp_rs2_data = r2data;
  endtask

  task automatic push(input lsu_control_signals_t c, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] sd, input logic [31:0] pc);
    exp_t e;
    e.ctrl = c; e.a = a; e.b = b; e.sd = sd; e.pc = pc;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    idle_inputs();
    repeat (2) @(posedge CLK);
    #1;
    tests_run++;
    if (bus.iss_valid !== 1'b0 || bus.disp_ready !== 1'b1 || bus.count !== '0) begin
      failures++;
      $display("FAIL reset_ctrl: got iss_valid=%b disp_ready=%b count=%0d, want 0 1 0",
               bus.iss_valid, bus.disp_ready, bus.count);
    end
    tests_run++;
    if (bus.iss_port_a !== '0 || bus.iss_port_b !== '0 || bus.iss_store_data !== '0 ||
        bus.iss_pc !== '0 || bus.iss_ctrl !== '0) begin
      failures++;
      $display("FAIL reset_data: got a=%h b=%h sd=%h pc=%h ctrl=%h, want all 0",
               bus.iss_port_a, bus.iss_port_b, bus.iss_store_data, bus.iss_pc, bus.iss_ctrl);
    end
    nRST = 1'b1;
    step();
  endtask

  task automatic test_ready_dispatch();
    bus.busy_ls = 1'b0;
    drive_disp(mk_ctrl(1'b0, 4'd1), 32'h100, 32'h8, 1'b1, 4'd0, 32'h1000, 1'b1, 4'd0, 32'h0);
    push(mk_ctrl(1'b0, 4'd1), 32'h1000, 32'h8, 32'h0, 32'h100);
    @(negedge CLK);
    tests_run++;
    if (bus.iss_valid !== 1'b0) begin
      failures++; $display("FAIL rd_empty_noissue: got iss_valid=%b want 0", bus.iss_valid);
    end
    step();
    bus.disp_valid = 1'b0;
    @(negedge CLK);
    tests_run++;
    if (bus.iss_valid !== 1'b1 || bus.count !== CNT_W'(1)) begin
      failures++; $display("FAIL rd_issue_next: got iss_valid=%b count=%0d want 1 1", bus.iss_valid, bus.count);
    end
    step();
    @(negedge CLK);
    tests_run++;
    if (bus.count !== '0 || bus.iss_valid !== 1'b0) begin
      failures++; $display("FAIL rd_drained: got count=%0d iss_valid=%b want 0 0", bus.count, bus.iss_valid);
    end
    step();
  endtask

  task automatic test_fill_block();
    bus.busy_ls = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_disp(mk_ctrl(i[0], CB_W'(i + 2)), 32'h200 + 32'(i * 4), 32'(i), 1'b1, '0, 32'h3000 + 32'(i),
                 1'b1, '0, 32'h5000 + 32'(i));
      if (i < 4) push(mk_ctrl(i[0], CB_W'(i + 2)), 32'h3000 + 32'(i), 32'(i), 32'h5000 + 32'(i),
                      32'h200 + 32'(i * 4));
      @(negedge CLK);
      tests_run++;
      if (bus.disp_ready !== 1'(i < 4)) begin
        failures++; $display("FAIL fill_ready[%0d]: got disp_ready=%b want %b", i, bus.disp_ready, 1'(i < 4));
      end
      step();
    end
    bus.disp_valid = 1'b0;
    @(negedge CLK);
    tests_run++;
    if (bus.count !== CNT_W'(4) || bus.iss_valid !== 1'b0) begin
      failures++; $display("FAIL fill_full: got count=%0d iss_valid=%b want 4 0", bus.count, bus.iss_valid);
    end
    step();
    bus.busy_ls = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      tests_run++;
      if (bus.iss_valid !== 1'b1 || bus.count !== CNT_W'(4 - k)) begin
        failures++; $display("FAIL drain[%0d]: got iss_valid=%b count=%0d want 1 %0d", k, bus.iss_valid, bus.count, 4 - k);
      end
      step();
    end
    @(negedge CLK);
    tests_run++;
    if (bus.count !== '0) begin
      failures++; $display("FAIL drain_empty: got count=%0d want 0", bus.count);
    end
    step();
  endtask

  task automatic test_full_no_passthrough();
    bus.busy_ls = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_disp(mk_ctrl(1'b0, CB_W'(8 + i)), 32'h700 + 32'(i), 32'h20, 1'b1, '0, 32'h7000 + 32'(i),
                 1'b1, '0, 32'h0);
      push(mk_ctrl(1'b0, CB_W'(8 + i)), 32'h7000 + 32'(i), 32'h20, 32'h0, 32'h700 + 32'(i));
      step();
    end
    bus.busy_ls = 1'b0;
    drive_disp(mk_ctrl(1'b1, 4'd15), 32'h7F0, 32'h24, 1'b1, '0, 32'h7777, 1'b1, '0, 32'h8888);
    @(negedge CLK);
    tests_run++;
    if (bus.disp_ready !== 1'b0 || bus.iss_valid !== 1'b1) begin
      failures++; $display("FAIL full_no_pass: got disp_ready=%b iss_valid=%b want 0 1", bus.disp_ready, bus.iss_valid);
    end
    step();
    push(mk_ctrl(1'b1, 4'd15), 32'h7777, 32'h24, 32'h8888, 32'h7F0);
    @(negedge CLK);
    tests_run++;
    if (bus.disp_ready !== 1'b1 || bus.count !== CNT_W'(3) || bus.iss_valid !== 1'b1) begin
      failures++; $display("FAIL simul_pre: got disp_ready=%b count=%0d iss_valid=%b want 1 3 1",
                           bus.disp_ready, bus.count, bus.iss_valid);
    end
    step();
    bus.disp_valid = 1'b0;
    @(negedge CLK);
    tests_run++;
    if (bus.count !== CNT_W'(3)) begin
      failures++; $display("FAIL simul_count: got count=%0d want 3", bus.count);
    end
    repeat (3) step();
    @(negedge CLK);
    tests_run++;
    if (bus.count !== '0) begin
      failures++; $display("FAIL simul_drain: got count=%0d want 0", bus.count);
    end
    step();
  endtask

  task automatic test_delayed_wakeup();
    bus.busy_ls = 1'b0;
    drive_disp(mk_ctrl(1'b1, 4'd2), 32'h400, 32'h10, 1'b1, '0, 32'h2000, 1'b0, 4'd3, 32'h0);
    step();
    bus.disp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.wb_valid = (c == 0); bus.wb_index = 4'd4; bus.wb_data = 32'hBAD;
      @(negedge CLK);
      tests_run++;
      if (bus.iss_valid !== 1'b0) begin
        failures++; $display("FAIL wake_wait[%0d]: got iss_valid=%b want 0", c, bus.iss_valid);
      end
      step();
    end
    bus.wb_valid = 1'b1; bus.wb_index = 4'd3; bus.wb_data = 32'hDEAD;
    push(mk_ctrl(1'b1, 4'd2), 32'h2000, 32'h10, 32'hDEAD, 32'h400);
    @(negedge CLK);
    tests_run++;
    if (bus.iss_valid !== 1'b0) begin
      failures++; $display("FAIL wake_registered: got iss_valid=%b want 0", bus.iss_valid);
    end
    step();
    bus.wb_valid = 1'b0;
    @(negedge CLK);
    tests_run++;
    if (bus.iss_valid !== 1'b1) begin
      failures++; $display("FAIL wake_issue: got iss_valid=%b want 1", bus.iss_valid);
    end
    step();
  endtask

  task automatic test_bypass();
    bus.busy_ls = 1'b0;
    drive_disp(mk_ctrl(1'b0, 4'd6), 32'h500, 32'h4, 1'b0, 4'd5, 32'hFFFF, 1'b1, '0, 32'h0);
    bus.wb_valid = 1'b1; bus.wb_index = 4'd5; bus.wb_data = 32'h42;
    push(mk_ctrl(1'b0, 4'd6), 32'h42, 32'h4, 32'h0, 32'h500);
    step();
    bus.disp_valid = 1'b0; bus.wb_valid = 1'b0;
    @(negedge CLK);
    tests_run++;
    if (bus.iss_valid !== 1'b1) begin
      failures++; $display("FAIL bypass_issue: got iss_valid=%b want 1", bus.iss_valid);
    end
    step();
  endtask

  task automatic test_ordering();
    bus.busy_ls = 1'b0;
    drive_disp(mk_ctrl(1'b0, 4'd9), 32'h600, 32'h0, 1'b0, 4'd7, 32'h0, 1'b1, '0, 32'h0);
    step();
    drive_disp(mk_ctrl(1'b0, 4'd10), 32'h604, 32'h4, 1'b1, '0, 32'h1234, 1'b1, '0, 32'h0);
    step();
    bus.disp_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      tests_run++;
      if (bus.iss_valid !== 1'b0 || bus.count !== CNT_W'(2)) begin
        failures++; $display("FAIL order_stall[%0d]: got iss_valid=%b count=%0d want 0 2", c, bus.iss_valid, bus.count);
      end
      step();
    end
    bus.wb_valid = 1'b1; bus.wb_index = 4'd7; bus.wb_data = 32'h77;
    push(mk_ctrl(1'b0, 4'd9), 32'h77, 32'h0, 32'h0, 32'h600);
    push(mk_ctrl(1'b0, 4'd10), 32'h1234, 32'h4, 32'h0, 32'h604);
    step();
    bus.wb_valid = 1'b0;
    repeat (2) step();
    @(negedge CLK);
    tests_run++;
    if (bus.count !== '0) begin
      failures++; $display("FAIL order_drain: got count=%0d want 0", bus.count);
    end
    step();
  endtask

  task automatic test_flush();
    bus.busy_ls = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_disp(mk_ctrl(1'b0, CB_W'(i)), 32'h900 + 32'(i), 32'h0, 1'b1, '0, 32'h9, 1'b1, '0, 32'h0);
      step();
    end
    drive_disp(mk_ctrl(1'b0, 4'd11), 32'h9F0, 32'h0, 1'b1, '0, 32'h9, 1'b1, '0, 32'h0);
    bus.flush = 1'b1; bus.busy_ls = 1'b0;
    @(negedge CLK);
    tests_run++;
    if (bus.iss_valid !== 1'b0 || bus.count !== CNT_W'(3)) begin
      failures++; $display("FAIL flush_cycle: got iss_valid=%b count=%0d want 0 3", bus.iss_valid, bus.count);
    end
    step();
    bus.flush = 1'b0; bus.disp_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      tests_run++;
      if (bus.count !== '0 || bus.iss_valid !== 1'b0) begin
        failures++; $display("FAIL flush_after[%0d]: got count=%0d iss_valid=%b want 0 0", c, bus.count, bus.iss_valid);
      end
      step();
    end
    drive_disp(mk_ctrl(1'b1, 4'd12), 32'hA00, 32'hC, 1'b1, '0, 32'hAAAA, 1'b1, '0, 32'hBBBB);
    push(mk_ctrl(1'b1, 4'd12), 32'hAAAA, 32'hC, 32'hBBBB, 32'hA00);
    step();
    bus.disp_valid = 1'b0;
    @(negedge CLK);
    tests_run++;
    if (bus.iss_valid !== 1'b1 || bus.count !== CNT_W'(1)) begin
      failures++; $display("FAIL post_flush_issue: got iss_valid=%b count=%0d want 1 1", bus.iss_valid, bus.count);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bus.busy_ls = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_disp(mk_ctrl(1'b0, CB_W'(i)), 32'hB00, 32'h0, 1'b1, '0, 32'h1, 1'b1, '0, 32'h0);
      step();
    end
    bus.disp_valid = 1'b0;
    #2;
    nRST = 1'b0;
    #1;
    tests_run++;
    if (bus.count !== '0 || bus.disp_ready !== 1'b1) begin
      failures++; $display("FAIL async_reset: got count=%0d disp_ready=%b want 0 1", bus.count, bus.disp_ready);
    end
    step();
    nRST = 1'b1;
    bus.busy_ls = 1'b0;
    step();
    @(negedge CLK);
    tests_run++;
    if (bus.count !== '0 || bus.iss_valid !== 1'b0) begin
      failures++; $display("FAIL reset_discard: got count=%0d iss_valid=%b want 0 0", bus.count, bus.iss_valid);
    end
    step();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_ready_dispatch();
    test_fill_block();
    test_full_no_passthrough();
    test_delayed_wakeup();
    test_bypass();
    test_ordering();
    test_flush();
    test_reset_mid();
    tests_run++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left: got %0d pending ops want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
